// File: rtl/decode_stage_riscv.sv
// RV32I decode stage: combinational decoder feeding a registered one- or two-entry
// output buffer with valid/ready handshakes on both the fetch and execute sides.
module decode_stage_riscv #(
    parameter int SKID  = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [31:0]      instr_i,
    input  logic             instr_valid_i,
    output logic             instr_ready_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [4:0]       alu_op_o,
    output logic [1:0]       a_sel_o,
    output logic [1:0]       b_sel_o,
    output logic [31:0]      imm_o,
    output logic [4:0]       rs1_o,
    output logic [4:0]       rs2_o,
    output logic [4:0]       rd_o,
    output logic             gpr_we_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [2:0]       mem_size_o,
    output logic             branch_o,
    output logic             jal_o,
    output logic             jalr_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] illegal_cnt_o
);

    // ALU encoding: arithmetic ops are {1'b0, funct7[5], funct3}, compares are {2'b11, funct3}
    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SRA = 5'b01101;
    localparam logic [4:0] ALU_SRL = 5'b00101;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_MISC   = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [1:0] A_RS1  = 2'd0;
    localparam logic [1:0] A_PC   = 2'd1;
    localparam logic [1:0] A_ZERO = 2'd2;
    localparam logic [1:0] B_RS2  = 2'd0;
    localparam logic [1:0] B_IMM  = 2'd1;
    localparam logic [1:0] B_FOUR = 2'd2;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    typedef struct packed {
        logic [4:0]  alu_op;
        logic [1:0]  a_sel;
        logic [1:0]  b_sel;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        gpr_we;
        logic        mem_req;
        logic        mem_we;
        logic [2:0]  mem_size;
        logic        branch;
        logic        jal;
        logic        jalr;
        logic        illegal;
    } dec_t;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
    dec_t        dec;
    dec_t        head;
    logic        in_fire;
    logic        out_fire;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    assign i_imm = {{20{instr_i[31]}}, instr_i[31:20]};
    assign s_imm = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign b_imm = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign u_imm = {instr_i[31:12], 12'b0};
    assign j_imm = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    always_comb begin
        dec        = '0;
        dec.rs1    = instr_i[19:15];
        dec.rs2    = instr_i[24:20];
        dec.rd     = instr_i[11:7];
        dec.alu_op = ALU_ADD;
        case (opcode)
            OPC_OP: begin
                dec.alu_op = {1'b0, funct7[5], funct3};
                dec.gpr_we = 1'b1;
                if (funct7 == 7'h20) begin
                    if (funct3 != 3'b000 && funct3 != 3'b101) dec.illegal = 1'b1;
                end else if (funct7 != 7'h00) begin
                    dec.illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                dec.alu_op = {2'b00, funct3};
                dec.b_sel  = B_IMM;
                dec.imm    = i_imm;
                dec.gpr_we = 1'b1;
                // Shifts carry only the shift amount; funct7 selects logical vs arithmetic right
                if (funct3 == 3'b001) begin
                    dec.imm = {27'b0, instr_i[24:20]};
                    if (funct7 != 7'h00) dec.illegal = 1'b1;
                end else if (funct3 == 3'b101) begin
                    dec.imm = {27'b0, instr_i[24:20]};
                    if (funct7 == 7'h00)      dec.alu_op = ALU_SRL;
                    else if (funct7 == 7'h20) dec.alu_op = ALU_SRA;
                    else                      dec.illegal = 1'b1;
                end
            end
            OPC_LUI: begin
                dec.a_sel  = A_ZERO;
                dec.b_sel  = B_IMM;
                dec.imm    = u_imm;
                dec.gpr_we = 1'b1;
            end
            OPC_AUIPC: begin
                dec.a_sel  = A_PC;
                dec.b_sel  = B_IMM;
                dec.imm    = u_imm;
                dec.gpr_we = 1'b1;
            end
            OPC_JAL: begin
                dec.a_sel  = A_PC;
                dec.b_sel  = B_FOUR;
                dec.imm    = j_imm;
                dec.gpr_we = 1'b1;
                dec.jal    = 1'b1;
            end
            OPC_JALR: begin
                dec.a_sel  = A_PC;
                dec.b_sel  = B_FOUR;
                dec.imm    = i_imm;
                dec.gpr_we = 1'b1;
                dec.jalr   = 1'b1;
                if (funct3 != 3'b000) dec.illegal = 1'b1;
            end
            OPC_BRANCH: begin
                dec.alu_op = {2'b11, funct3};
                dec.imm    = b_imm;
                dec.branch = 1'b1;
                if (funct3 == 3'b010 || funct3 == 3'b011) dec.illegal = 1'b1;
            end
            OPC_LOAD: begin
                dec.b_sel    = B_IMM;
                dec.imm      = i_imm;
                dec.gpr_we   = 1'b1;
                dec.mem_req  = 1'b1;
                dec.mem_size = funct3;
                if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) dec.illegal = 1'b1;
            end
            OPC_STORE: begin
                dec.b_sel    = B_IMM;
                dec.imm      = s_imm;
                dec.mem_req  = 1'b1;
                dec.mem_we   = 1'b1;
                dec.mem_size = funct3;
                if (funct3[2] || funct3 == 3'b011) dec.illegal = 1'b1;
            end
            OPC_MISC, OPC_SYSTEM: begin
                dec.alu_op = ALU_ADD;
            end
            default: dec.illegal = 1'b1;
        endcase

        if (dec.illegal) begin
            dec.alu_op   = ALU_ADD;
            dec.a_sel    = A_RS1;
            dec.b_sel    = B_RS2;
            dec.imm      = '0;
            dec.gpr_we   = 1'b0;
            dec.mem_req  = 1'b0;
            dec.mem_we   = 1'b0;
            dec.mem_size = 3'b000;
            dec.branch   = 1'b0;
            dec.jal      = 1'b0;
            dec.jalr     = 1'b0;
        end
        if (dec.rd == 5'd0) dec.gpr_we = 1'b0;
    end

    assign in_fire  = instr_valid_i & instr_ready_o;
    assign out_fire = out_valid_o & out_ready_i;

    generate
        if (SKID != 0) begin : g_skid
            logic [1:0] state_reg, state_next;
            logic       ready_reg;
            dec_t       head_reg, skid_reg;

            always_comb begin
                state_next = state_reg;
                case (state_reg)
                    ST_EMPTY: if (in_fire) state_next = ST_ONE;
                    ST_ONE: begin
                        if (in_fire && !out_fire)      state_next = ST_TWO;
                        else if (!in_fire && out_fire) state_next = ST_EMPTY;
                    end
                    ST_TWO:   if (out_fire) state_next = ST_ONE;
                    default:  state_next = ST_EMPTY;
                endcase
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    state_reg <= ST_EMPTY;
                    ready_reg <= 1'b1;
                    head_reg  <= '0;
                    skid_reg  <= '0;
                end else begin
                    state_reg <= state_next;
                    // Ready is registered so execute-side backpressure never reaches fetch combinationally
                    ready_reg <= (state_next != ST_TWO);
                    case (state_reg)
                        ST_EMPTY: if (in_fire) head_reg <= dec;
                        ST_ONE: begin
                            if (in_fire && out_fire) head_reg <= dec;
                            else if (in_fire)        skid_reg <= dec;
                        end
                        ST_TWO:   if (out_fire) head_reg <= skid_reg;
                        default:  ;
                    endcase
                end
            end

            assign instr_ready_o = ready_reg;
            assign out_valid_o   = (state_reg != ST_EMPTY);
            assign head          = head_reg;
        end else begin : g_single
            logic full_reg;
            dec_t head_reg;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    full_reg <= 1'b0;
                    head_reg <= '0;
                end else begin
                    if (in_fire)       full_reg <= 1'b1;
                    else if (out_fire) full_reg <= 1'b0;
                    if (in_fire) head_reg <= dec;
                end
            end

            assign instr_ready_o = !full_reg | out_ready_i;
            assign out_valid_o   = full_reg;
            assign head          = head_reg;
        end
    endgenerate

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_reg <= '0;
        end else if (in_fire && dec.illegal && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign illegal_cnt_o = cnt_reg;
    assign alu_op_o      = head.alu_op;
    assign a_sel_o       = head.a_sel;
    assign b_sel_o       = head.b_sel;
    assign imm_o         = head.imm;
    assign rs1_o         = head.rs1;
    assign rs2_o         = head.rs2;
    assign rd_o          = head.rd;
    assign gpr_we_o      = head.gpr_we;
    assign mem_req_o     = head.mem_req;
    assign mem_we_o      = head.mem_we;
    assign mem_size_o    = head.mem_size;
    assign branch_o      = head.branch;
    assign jal_o         = head.jal;
    assign jalr_o        = head.jalr;
    assign illegal_o     = head.illegal;

endmodule

// File: tb/tb_decode_stage_riscv.sv
// Directed bench for decode_stage_riscv: a decode vector table on a SKID=1 instance plus
// hand sequences for backpressure, async reset and a SKID=0 / CNT_W=2 instance.
module tb_decode_stage_riscv;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    // Main instance: SKID=1, CNT_W=16
    logic [31:0] instr;
    logic        instr_valid, instr_ready, out_valid, out_ready;
    logic [4:0]  alu_op, rs1, rs2, rd;
    logic [1:0]  a_sel, b_sel;
    logic [31:0] imm;
    logic        gpr_we, mem_req, mem_we, branch, jal, jalr, illegal;
    logic [2:0]  mem_size;
    logic [15:0] illegal_cnt;

    // Second instance: SKID=0, CNT_W=2
    logic [31:0] instr2;
    logic        instr_valid2, instr_ready2, out_valid2, out_ready2;
    logic [4:0]  alu_op2, rs1_2, rs2_2, rd2;
    logic [1:0]  a_sel2, b_sel2;
    logic [31:0] imm2;
    logic        gpr_we2, mem_req2, mem_we2, branch2, jal2, jalr2, illegal2;
    logic [2:0]  mem_size2;
    logic [1:0]  illegal_cnt2;

    decode_stage_riscv #(.SKID(1), .CNT_W(16)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .instr_i(instr), .instr_valid_i(instr_valid), .instr_ready_o(instr_ready),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .alu_op_o(alu_op), .a_sel_o(a_sel), .b_sel_o(b_sel), .imm_o(imm),
        .rs1_o(rs1), .rs2_o(rs2), .rd_o(rd),
        .gpr_we_o(gpr_we), .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_size_o(mem_size),
        .branch_o(branch), .jal_o(jal), .jalr_o(jalr), .illegal_o(illegal),
        .illegal_cnt_o(illegal_cnt)
    );

    decode_stage_riscv #(.SKID(0), .CNT_W(2)) dut2 (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .instr_i(instr2), .instr_valid_i(instr_valid2), .instr_ready_o(instr_ready2),
        .out_valid_o(out_valid2), .out_ready_i(out_ready2),
        .alu_op_o(alu_op2), .a_sel_o(a_sel2), .b_sel_o(b_sel2), .imm_o(imm2),
        .rs1_o(rs1_2), .rs2_o(rs2_2), .rd_o(rd2),
        .gpr_we_o(gpr_we2), .mem_req_o(mem_req2), .mem_we_o(mem_we2), .mem_size_o(mem_size2),
        .branch_o(branch2), .jal_o(jal2), .jalr_o(jalr2), .illegal_o(illegal2),
        .illegal_cnt_o(illegal_cnt2)
    );

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  alu;
        logic [1:0]  a;
        logic [1:0]  b;
        logic [31:0] imm;
        logic        we, req, mwe;
        logic [2:0]  sz;
        logic        br, jl, jlr, ill;
    } vec_t;

    localparam int NV = 21;
    vec_t tbl [NV];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic logic [14:0] ctrl_main();
        return {a_sel, b_sel, gpr_we, mem_req, mem_we, mem_size, branch, jal, jalr, illegal};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int exp_cnt;
        int n;
        // instr, alu, a, b, imm, we, req, mwe, sz, br, jal, jalr, ill
        tbl[0]  = '{32'h002081B3, 5'b00000, 2'd0, 2'd0, 32'h0,        1, 0, 0, 3'b000, 0, 0, 0, 0}; // add x3,x1,x2
        tbl[1]  = '{32'h407302B3, 5'b01000, 2'd0, 2'd0, 32'h0,        1, 0, 0, 3'b000, 0, 0, 0, 0}; // sub x5,x6,x7
        tbl[2]  = '{32'hFE208EE3, 5'b11000, 2'd0, 2'd0, 32'hFFFFFFFC, 0, 0, 0, 3'b000, 1, 0, 0, 0}; // beq -4
        tbl[3]  = '{32'h0020A423, 5'b00000, 2'd0, 2'd1, 32'h8,        0, 1, 1, 3'b010, 0, 0, 0, 0}; // sw x2,8(x1)
        tbl[4]  = '{32'h00100013, 5'b00000, 2'd0, 2'd1, 32'h1,        0, 0, 0, 3'b000, 0, 0, 0, 0}; // addi x0,x0,1
        tbl[5]  = '{32'h00000000, 5'b00000, 2'd0, 2'd0, 32'h0,        0, 0, 0, 3'b000, 0, 0, 0, 1}; // all zero
        tbl[6]  = '{32'h0040A283, 5'b00000, 2'd0, 2'd1, 32'h4,        1, 1, 0, 3'b010, 0, 0, 0, 0}; // lw x5,4(x1)
        tbl[7]  = '{32'h123450B7, 5'b00000, 2'd2, 2'd1, 32'h12345000, 1, 0, 0, 3'b000, 0, 0, 0, 0}; // lui
        tbl[8]  = '{32'h00001117, 5'b00000, 2'd1, 2'd1, 32'h00001000, 1, 0, 0, 3'b000, 0, 0, 0, 0}; // auipc
        tbl[9]  = '{32'h008000EF, 5'b00000, 2'd1, 2'd2, 32'h8,        1, 0, 0, 3'b000, 0, 1, 0, 0}; // jal x1,8
        tbl[10] = '{32'h00008067, 5'b00000, 2'd1, 2'd2, 32'h0,        0, 0, 0, 3'b000, 0, 0, 1, 0}; // jalr x0
        tbl[11] = '{32'h40525193, 5'b01101, 2'd0, 2'd1, 32'h5,        1, 0, 0, 3'b000, 0, 0, 0, 0}; // srai
        tbl[12] = '{32'h40121093, 5'b00000, 2'd0, 2'd0, 32'h0,        0, 0, 0, 3'b000, 0, 0, 0, 1}; // slli f7=20
        tbl[13] = '{32'h0020E463, 5'b11110, 2'd0, 2'd0, 32'h8,        0, 0, 0, 3'b000, 1, 0, 0, 0}; // bltu
        tbl[14] = '{32'h0020A463, 5'b00000, 2'd0, 2'd0, 32'h0,        0, 0, 0, 3'b000, 0, 0, 0, 1}; // branch f3=010
        tbl[15] = '{32'h0000000F, 5'b00000, 2'd0, 2'd0, 32'h0,        0, 0, 0, 3'b000, 0, 0, 0, 0}; // fence
        tbl[16] = '{32'h00000073, 5'b00000, 2'd0, 2'd0, 32'h0,        0, 0, 0, 3'b000, 0, 0, 0, 0}; // ecall
        tbl[17] = '{32'h022081B3, 5'b00000, 2'd0, 2'd0, 32'h0,        0, 0, 0, 3'b000, 0, 0, 0, 1}; // mul
        tbl[18] = '{32'h00009067, 5'b00000, 2'd0, 2'd0, 32'h0,        0, 0, 0, 3'b000, 0, 0, 0, 1}; // jalr f3=1
        tbl[19] = '{32'h002081B0, 5'b00000, 2'd0, 2'd0, 32'h0,        0, 0, 0, 3'b000, 0, 0, 0, 1}; // [1:0]=00
        tbl[20] = '{32'h0020C1B3, 5'b00100, 2'd0, 2'd0, 32'h0,        1, 0, 0, 3'b000, 0, 0, 0, 0}; // xor

        instr = '0; instr_valid = 0; out_ready = 0;
        instr2 = '0; instr_valid2 = 0; out_ready2 = 0;
        rst_ni = 0;
        repeat (2) tick();

        // Reset state
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(instr_ready), 32'd1);
        chk("rst_cnt", 32'(illegal_cnt), 32'd0);
        chk("rst_alu", 32'(alu_op), 32'd0);
        chk("rst_imm", imm, 32'd0);
        chk("rst_ctrl", 32'(ctrl_main()), 32'd0);
        rst_ni = 1;
        tick();

        // Decode table, one word at a time
        exp_cnt = 0;
        for (int i = 0; i < NV; i++) begin
            n = 0;
            while (!instr_ready && n < 20) begin tick(); n++; end
            if (n == 20) chk("ready_timeout", 32'(instr_ready), 32'd1);
            instr = tbl[i].instr; instr_valid = 1; out_ready = 1;
            tick();
            instr_valid = 0;
            if (tbl[i].ill) exp_cnt++;
            $display("vec %0d instr=%08h alu=%05b imm=%08h ill=%0b cnt=%0d",
                     i, tbl[i].instr, alu_op, imm, illegal, illegal_cnt);
            chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("v%0d_alu", i), 32'(alu_op), 32'(tbl[i].alu));
            chk($sformatf("v%0d_imm", i), imm, tbl[i].imm);
            chk($sformatf("v%0d_ctrl", i), 32'(ctrl_main()),
                32'({tbl[i].a, tbl[i].b, tbl[i].we, tbl[i].req, tbl[i].mwe, tbl[i].sz,
                     tbl[i].br, tbl[i].jl, tbl[i].jlr, tbl[i].ill}));
            chk($sformatf("v%0d_cnt", i), 32'(illegal_cnt), 32'(exp_cnt));
            if (i == 0) chk("v0_rd", 32'(rd), 32'd3);
            tick();
        end
        chk("drained", 32'(out_valid), 32'd0);

        // Backpressure: three words with execute stalled, two accepted
        out_ready = 0;
        instr = 32'h002081B3; instr_valid = 1;
        tick();
        instr = 32'h407302B3;
        tick();
        instr = 32'h0020C1B3;
        $display("bp fill ready=%0b valid=%0b alu=%05b", instr_ready, out_valid, alu_op);
        chk("bp_ready_low", 32'(instr_ready), 32'd0);
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_head_alu", 32'(alu_op), 32'b00000);
        tick();
        chk("bp_hold_ready", 32'(instr_ready), 32'd0);
        chk("bp_hold_alu", 32'(alu_op), 32'b00000);
        chk("bp_hold_rd", 32'(rd), 32'd3);
        out_ready = 1;
        tick();
        $display("bp drain1 alu=%05b ready=%0b", alu_op, instr_ready);
        chk("bp_drain1_alu", 32'(alu_op), 32'b01000);
        chk("bp_drain1_ready", 32'(instr_ready), 32'd1);
        tick();
        instr_valid = 0;
        $display("bp drain2 alu=%05b", alu_op);
        chk("bp_drain2_alu", 32'(alu_op), 32'b00100);
        chk("bp_drain2_valid", 32'(out_valid), 32'd1);
        tick();
        chk("bp_empty", 32'(out_valid), 32'd0);

        // Async reset while holding two entries
        out_ready = 0;
        instr = 32'h00000000; instr_valid = 1;
        tick();
        tick();
        instr_valid = 0;
        chk("rst2_full", 32'(instr_ready), 32'd0);
        #2 rst_ni = 0;
        #1;
        $display("async reset valid=%0b ready=%0b cnt=%0d", out_valid, instr_ready, illegal_cnt);
        chk("rst2_valid", 32'(out_valid), 32'd0);
        chk("rst2_ready", 32'(instr_ready), 32'd1);
        chk("rst2_cnt", 32'(illegal_cnt), 32'd0);
        tick();
        rst_ni = 1;
        out_ready = 1;
        tick();
        tick();
        chk("rst2_no_stale", 32'(out_valid), 32'd0);

        // SKID=0 instance: saturating 2-bit counter and combinational ready
        out_ready2 = 1;
        instr2 = 32'h00000000; instr_valid2 = 1;
        tick();
        chk("s0_cnt1", 32'(illegal_cnt2), 32'd1);
        chk("s0_illegal", 32'(illegal2), 32'd1);
        for (int k = 0; k < 4; k++) tick();
        instr_valid2 = 0;
        $display("skid0 cnt=%0d valid=%0b", illegal_cnt2, out_valid2);
        chk("s0_cnt_sat", 32'(illegal_cnt2), 32'd3);
        out_ready2 = 0;
        #1;
        chk("s0_ready_full", 32'(instr_ready2), 32'd0);
        chk("s0_valid_full", 32'(out_valid2), 32'd1);
        out_ready2 = 1;
        #1;
        chk("s0_ready_pass", 32'(instr_ready2), 32'd1);
        tick();
        chk("s0_empty", 32'(out_valid2), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
